// File: rtl/traffic_light_state_machine.sv
// Three-phase RED -> GREEN -> YELLOW sequencer with per-phase cycle counts; lamps decode state only.
// Latency: lamp change one edge after the phase count expires; reset/enable-low park at RED on the next edge.
module traffic_light_state_machine #(
    parameter int RED_CYCLES    = 32,
    parameter int GREEN_CYCLES  = 24,
    parameter int YELLOW_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic red,
    output logic yellow,
    output logic green
);

    typedef enum logic [1:0] {
        S_RED    = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = S_RED;
        cnt_d   = '0;
        if (enable) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                S_RED: begin
                    state_d = S_RED;
                    if (cnt_q == RED_LAST) begin
                        state_d = S_GREEN;
                        cnt_d   = '0;
                    end
                end
                S_GREEN: begin
                    state_d = S_GREEN;
                    if (cnt_q == GREEN_LAST) begin
                        state_d = S_YELLOW;
                        cnt_d   = '0;
                    end
                end
                S_YELLOW: begin
                    state_d = S_YELLOW;
                    if (cnt_q == YELLOW_LAST) begin
                        state_d = S_RED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_RED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // reset_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= S_RED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Unused encoding shows red so the head stays one-hot while it recovers.
    assign green  = (state_q == S_GREEN);
    assign yellow = (state_q == S_YELLOW);
    assign red    = !(green || yellow);

endmodule

// File: tb/tb_traffic_light_state_machine.sv
// Bench for traffic_light_state_machine: vector table, edge-count sequences, random run vs reference model.
module tb_traffic_light_state_machine;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic red, yellow, green;

    int errors = 0;
    int checks = 0;

    int dur [3] = '{32, 24, 8};
    int m_phase   = 0;
    int m_elapsed = 0;

    traffic_light_state_machine dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .red    (red),
        .yellow (yellow),
        .green  (green)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        int         n;
        logic [2:0] exp;  // {red, yellow, green}
        string      name;
    } vec_t;

    vec_t vt[$];

    function automatic logic [2:0] model_lamps();
        case (m_phase)
            0:       return 3'b100;
            1:       return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    function automatic void model_edge(input logic r, input logic e);
        if (r || !e) begin
            m_phase   = 0;
            m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == dur[m_phase]) begin
                m_phase   = (m_phase + 1) % 3;
                m_elapsed = 0;
            end
        end
    endfunction

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: lamps(ryg)=%b required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // One edge: drive, clock, update model, then compare on the falling edge.
    task automatic tick(input logic r, input logic e);
        reset_n = r;
        enable  = e;
        @(posedge clk);
        model_edge(r, e);
        @(negedge clk);
        check3("model", {red, yellow, green}, model_lamps());
        check_int("onehot", int'(red) + int'(yellow) + int'(green), 1);
    endtask

    task automatic count_until(input string name, input int which, input int req);
        int n;
        logic [2:0] l;
        n = 0;
        do begin
            tick(1'b0, 1'b1);
            n++;
            l = {red, yellow, green};
        end while (l[which] !== 1'b1 && n < 200);
        check_int(name, n, req);
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;

        vt.push_back('{1'b1, 1'b0, 1,  3'b100, "reset"});
        vt.push_back('{1'b0, 1'b0, 5,  3'b100, "parked"});
        vt.push_back('{1'b0, 1'b1, 3,  3'b100, "early_red"});
        vt.push_back('{1'b0, 1'b1, 28, 3'b100, "red_31"});
        vt.push_back('{1'b0, 1'b1, 1,  3'b001, "green_rise"});
        vt.push_back('{1'b0, 1'b1, 23, 3'b001, "green_hold"});
        vt.push_back('{1'b0, 1'b1, 1,  3'b010, "yellow_rise"});
        vt.push_back('{1'b0, 1'b1, 7,  3'b010, "yellow_hold"});
        vt.push_back('{1'b0, 1'b1, 1,  3'b100, "red_again"});
        vt.push_back('{1'b0, 1'b1, 31, 3'b100, "red_hold2"});
        vt.push_back('{1'b0, 1'b1, 11, 3'b001, "mid_green"});
        vt.push_back('{1'b0, 1'b0, 1,  3'b100, "glitch_red"});
        vt.push_back('{1'b0, 1'b1, 31, 3'b100, "restart_red"});
        vt.push_back('{1'b0, 1'b1, 1,  3'b001, "restart_green"});
        vt.push_back('{1'b1, 1'b1, 3,  3'b100, "rst_en1"});
        vt.push_back('{1'b1, 1'b0, 1,  3'b100, "rst_en0"});
        vt.push_back('{1'b1, 1'b1, 1,  3'b100, "rst_en1b"});
        vt.push_back('{1'b0, 1'b1, 3,  3'b100, "pulse_a"});
        vt.push_back('{1'b0, 1'b0, 3,  3'b100, "pulse_b"});
        vt.push_back('{1'b0, 1'b1, 3,  3'b100, "pulse_c"});

        foreach (vt[i]) begin
            for (int k = 0; k < vt[i].n; k++) tick(vt[i].r, vt[i].e);
            check3(vt[i].name, {red, yellow, green}, vt[i].exp);
        end

        // Exact edge counts for a full cycle starting from parked RED.
        tick(1'b0, 1'b0);
        count_until("edges_to_green",  0, 32);
        count_until("edges_to_yellow", 1, 24);
        count_until("edges_to_red",    2, 8);
        count_until("edges_to_green2", 0, 32);

        // Enable drop late in GREEN restarts a full RED phase.
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check3("drop_green", {red, yellow, green}, 3'b100);
        count_until("edges_after_drop", 0, 32);

        // Random run: enable mostly high, occasional drops and resets.
        for (int k = 0; k < 3000; k++) begin
            logic r, e;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 99) >= 3);
            tick(r, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
